downsampling_processor: RTL and testbench

- Single-clock image downsampling engine with a private 64K x 8 byte memory.
- The host loads a 256x256 8-bit image through a byte-wide port, then starts processing.
- The engine applies a 3x3 Gaussian filter with stride 2, giving a 127x127 image that it writes back in place from address 0.
- The host then reads the result back through the same port.

---
 rtl/downsampling_processor.sv | 125 ++++++++++++
 tb/tb_downsampling_processor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/downsampling_processor.sv
// rtl/downsampling_processor.sv - 3x3 Gaussian stride-2 downsampler over a private byte memory
// Optional DOWNSAMPLE_ROUND_EN: round-half-up with saturation instead of truncation.
module downsampling_processor #(
  parameter int IMG_W  = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] add_in,
  input  logic              data_write,
  input  logic              data_read,
  input  logic              selection,
  output logic              finish,
  output logic [DATA_W-1:0] data_out
);

  localparam int OUT_W = (IMG_W - 1) / 2;
  localparam int SUM_W = DATA_W + 4;

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, NEXT, DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] i, j, out_addr, row, col, rd_addr;
  logic [3:0]        k;
  logic [1:0]        r, c, wsh, wsh_q;
  logic [SUM_W-1:0]  acc;
  logic [DATA_W-1:0] result;
  logic              run;

  assign run = enable & selection;

  // Window tap (r,c) of output (i,j); weight is 1 << (centre row + centre col)
  assign row     = (i << 1) + ADDR_W'(r);
  assign col     = (j << 1) + ADDR_W'(c);
  assign rd_addr = row * ADDR_W'(IMG_W) + col;
  assign wsh     = 2'(r == 2'd1) + 2'(c == 2'd1);

`ifdef DOWNSAMPLE_ROUND_EN
  logic [SUM_W-4:0] rnd_hi;
  assign rnd_hi = (SUM_W-3)'(({1'b0, acc} + (SUM_W+1)'(8)) >> 4);
  assign result = rnd_hi[SUM_W-4] ? '1 : rnd_hi[DATA_W-1:0];
`else
  assign result = acc[SUM_W-1:4];
`endif

  always_ff @(posedge clka or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    case (state)
      IDLE:  if (run) state_nx = FETCH;
      FETCH: if (k == 4'd9) state_nx = WRITE;
      WRITE: state_nx = NEXT;
      NEXT:  if (i == ADDR_W'(OUT_W-1) && j == ADDR_W'(OUT_W-1)) state_nx = DONE;
             else state_nx = FETCH;
      DONE:  finish = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (!run) state_nx = IDLE;
  end

  // Reads issue on k=0..8; each tap is accumulated one cycle later (k=1..9)
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      i <= '0; j <= '0; out_addr <= '0;
      k <= '0; r <= '0; c <= '0; wsh_q <= '0; acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          i <= '0; j <= '0; out_addr <= '0;
          k <= '0; r <= '0; c <= '0; wsh_q <= '0; acc <= '0;
        end
        FETCH: begin
          k     <= k + 4'd1;
          wsh_q <= wsh;
          if (c == 2'd2) begin
            c <= '0;
            r <= r + 2'd1;
          end else begin
            c <= c + 2'd1;
          end
          if (k == 4'd0) acc <= '0;
          else           acc <= acc + (SUM_W'(mem_q) << wsh_q);
        end
        NEXT: begin
          k <= '0; r <= '0; c <= '0;
          out_addr <= out_addr + ADDR_W'(1);
          if (j == ADDR_W'(OUT_W-1)) begin
            j <= '0;
            i <= i + ADDR_W'(1);
          end else begin
            j <= j + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output address is always below every input still to be read, so in-place is safe
  always_ff @(posedge clka) begin
    if (selection && state == WRITE)
      mem[out_addr] <= result;
    else if (!selection && data_write)
      mem[add_in] <= data_in;
    mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset)
      data_out <= '0;
    else if (!selection && data_read && !data_write)
      data_out <= mem[add_in];
  end

endmodule

// File: tb/tb_downsampling_processor.sv
// tb/tb_downsampling_processor.sv - scoreboard bench for downsampling_processor on a reduced image size
module tb_downsampling_processor;

  localparam int IMG_W  = 32;
  localparam int ADDR_W = 16;
  localparam int OUT_W  = (IMG_W - 1) / 2;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int NOUT   = OUT_W * OUT_W;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  data_in = '0;
  logic [15:0] add_in = '0;
  logic        data_write = 1'b0;
  logic        data_read = 1'b0;
  logic        selection = 1'b0;
  logic        finish;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] img     [NPIX];
  logic [7:0] exp_mem [NPIX];
  logic [7:0] exp_q   [$];
  logic       rd_pend = 1'b0;

  downsampling_processor #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clka(clka), .reset(reset), .enable(enable), .data_in(data_in),
    .add_in(add_in), .data_write(data_write), .data_read(data_read),
    .selection(selection), .finish(finish), .data_out(data_out)
  );

  always #5 clka = ~clka;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: a read accepted on a rising edge must show on data_out by the next falling edge
  always @(posedge clka) rd_pend <= data_read && !data_write && !selection && !reset;

  always @(negedge clka) begin : monitor
    logic [7:0] e;
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %02h required none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL rd_data got %02h required %02h", data_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  // Reference: straight weighted sum over the original image, row-major outputs at i*OUT_W+j
  task automatic build_expected();
    int sum, v;
    for (int a = 0; a < NPIX; a++) exp_mem[a] = img[a];
    for (int oi = 0; oi < OUT_W; oi++)
      for (int oj = 0; oj < OUT_W; oj++) begin
        sum = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            sum += (dr == 1 ? 2 : 1) * (dc == 1 ? 2 : 1) *
                   int'(img[(2*oi + dr) * IMG_W + 2*oj + dc]);
`ifdef DOWNSAMPLE_ROUND_EN
        v = (sum + 8) / 16;
        if (v > 255) v = 255;
`else
        v = sum / 16;
`endif
        exp_mem[oi * OUT_W + oj] = 8'(v);
      end
  endtask

  task automatic host_write(input int a, input int d);
    add_in = a[15:0]; data_in = d[7:0]; data_write = 1'b1;
    @(negedge clka);
    data_write = 1'b0;
  endtask

  task automatic host_read(input int a, input logic [7:0] e);
    add_in = a[15:0]; data_read = 1'b1;
    exp_q.push_back(e);
    @(negedge clka);
    data_read = 1'b0;
  endtask

  task automatic load_image();
    selection = 1'b0;
    for (int a = 0; a < NPIX; a++) host_write(a, int'(img[a]));
  endtask

  task automatic read_back(input string name);
    selection = 1'b0;
    for (int a = 0; a < NPIX; a++) host_read(a, exp_mem[a]);
    @(negedge clka);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_engine(input string name);
    int cyc = 0;
    selection = 1'b1; enable = 1'b1;
    while (!finish && cyc < 12*NOUT + 20) begin
      @(negedge clka);
      cyc++;
    end
    check({name, "_finish"}, int'(finish), 1);
    checks++;
    if (cyc < 12*NOUT || cyc > 12*NOUT + 4) begin
      errors++;
      $display("FAIL %s_latency got %0d cycles required %0d..%0d", name, cyc, 12*NOUT, 12*NOUT+4);
    end
    repeat (3) @(negedge clka);
    check({name, "_finish_held"}, int'(finish), 1);
    enable = 1'b0; selection = 1'b0;
    @(negedge clka);
    check({name, "_finish_drop"}, int'(finish), 0);
  endtask

  task automatic full_test(input string name);
    build_expected();
    load_image();
    run_engine(name);
    read_back(name);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clka);
    check("reset_finish", int'(finish), 0);
    check("reset_data_out", int'(data_out), 0);
    reset = 1'b0;
    @(negedge clka);

    // Host loopback, write-wins on both strobes, strobes ignored under engine ownership
    host_write(16'h1234, 8'hA5);
    host_write(16'hFFFF, 8'h5A);
    host_read(16'h1234, 8'hA5);
    host_read(16'hFFFF, 8'h5A);
    add_in = 16'hFFFF; data_in = 8'h33; data_write = 1'b1; data_read = 1'b1;
    @(negedge clka);
    data_write = 1'b0; data_read = 1'b0;
    check("both_strobes_hold", int'(data_out), 8'h5A);
    host_read(16'hFFFF, 8'h33);
    selection = 1'b1;
    add_in = 16'h1234; data_in = 8'h00; data_write = 1'b1;
    @(negedge clka);
    data_write = 1'b0; data_read = 1'b1;
    @(negedge clka);
    data_read = 1'b0; selection = 1'b0;
    check("engine_owned_hold", int'(data_out), 8'h33);
    host_read(16'h1234, 8'hA5);

    // Uniform image with an abort at cycle 1000, then a fresh run
    for (int a = 0; a < NPIX; a++) img[a] = 8'd100;
    build_expected();
    load_image();
    selection = 1'b1; enable = 1'b1;
    repeat (1000) @(negedge clka);
    enable = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clka);
      if (finish !== 1'b0) bad++;
    end
    check("abort_finish_low", bad, 0);
    run_engine("uniform");
    read_back("uniform");

    for (int a = 0; a < NPIX; a++) img[a] = 8'd0;
    img[1*IMG_W + 1] = 8'd16;
    full_test("impulse");

    for (int a = 0; a < NPIX; a++) img[a] = 8'd0;
    img[2*IMG_W + 2] = 8'd16;
    full_test("edge");

    for (int a = 0; a < NPIX; a++) img[a] = 8'd0;
    img[0] = 8'd8;
    full_test("rounding");

    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 255));
      full_test("random");
    end

    // Reset mid-run: finish and data_out clear without waiting for an edge
    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 255));
    img[5] = 8'hC3;
    load_image();
    host_read(5, 8'hC3);
    @(negedge clka);
    selection = 1'b1; enable = 1'b1;
    repeat (500) @(negedge clka);
    reset = 1'b1;
    #1;
    check("midrun_reset_finish", int'(finish), 0);
    check("midrun_reset_data_out", int'(data_out), 0);
    enable = 1'b0; selection = 1'b0;
    @(negedge clka);
    reset = 1'b0;
    repeat (2) @(negedge clka);
    check("post_reset_finish", int'(finish), 0);

    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 255));
    full_test("post_reset");

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
